// File: rtl/vmx_result_collector.sv
// vmx_result_collector
//   Collects skewed product lanes from a systolic array. It realigns each
//   vector pass, accumulates acc_len passes per lane with two's-complement
//   wrap, and queues the finished sums in an output FIFO.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid        row-0 product of a pass is on lane 0 this cycle
//   product         SIZE lanes of PRODUCT_BITLEN, lane i arrives i cycles late
//   acc_len         passes per result (0 means 1), taken on the first beat
//   out_valid/ready FIFO head handshake
//   out_data        FIFO head, SIZE lanes of ACC_BITLEN
//   fifo_count      occupied FIFO entries (0..FIFO_DEPTH)
//   overflow        sticky: a finished result was dropped on a full FIFO
module vmx_result_collector #(
  parameter int SIZE           = 4,
  parameter int PRODUCT_BITLEN = 32,
  parameter int ACC_BITLEN     = 40,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [PRODUCT_BITLEN*SIZE-1:0] product,
  input  logic [7:0]                     acc_len,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_BITLEN*SIZE-1:0]     out_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow
);

  localparam int PB    = PRODUCT_BITLEN;
  localparam int AB    = ACC_BITLEN;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic signed [AB-1:0] sext(input logic signed [PB-1:0] p);
    return AB'(p);
  endfunction

  // ---- stage: tag pipeline, v[k] marks lane k of a pass being present
  logic [SIZE-1:0] v;
  logic [SIZE-2:0] tag_q;

  assign v = {tag_q, in_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= v[SIZE-2:0];
  end

  // ---- stage: deskew, every lane lands on the cycle v[SIZE-1] is high
  logic [PB*SIZE-1:0] aligned;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    localparam int D = SIZE - 1 - i;
    if (D == 0) begin : g_direct
      assign aligned[i*PB +: PB] = product[i*PB +: PB];
    end else begin : g_skew
      logic [PB-1:0] sr_q [D];
      // Each slot advances only with its own tag so back-to-back passes
      // stay separated.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < D; j++) sr_q[j] <= '0;
        end else begin
          if (v[i]) sr_q[0] <= product[i*PB +: PB];
          for (int j = 1; j < D; j++) begin
            if (v[i+j]) sr_q[j] <= sr_q[j-1];
          end
        end
      end
      assign aligned[i*PB +: PB] = sr_q[D-1];
    end
  end

  // ---- stage: accumulator FSM
  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t              state_q, state_d;
  logic [AB*SIZE-1:0]  acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          len_q, len_d;
  logic                push_q, push_d;
  logic [AB*SIZE-1:0]  ext_w, sum_w;
  logic [7:0]          cnt_inc;
  logic                beat;

  assign beat    = v[SIZE-1];
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    ext_w = '0;
    sum_w = '0;
    for (int i = 0; i < SIZE; i++) begin
      ext_w[i*AB +: AB] = sext(aligned[i*PB +: PB]);
      sum_w[i*AB +: AB] = acc_q[i*AB +: AB] + ext_w[i*AB +: AB];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    push_d  = 1'b0;
    if (beat) begin
      case (state_q)
        S_IDLE: begin
          len_d = (acc_len == 8'd0) ? 8'd1 : acc_len;
          acc_d = ext_w;
          if (len_d == 8'd1) begin
            push_d = 1'b1;
          end else begin
            cnt_d   = 8'd1;
            state_d = S_ACC;
          end
        end
        S_ACC: begin
          acc_d = sum_w;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            push_d  = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= 8'd1;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      push_q  <= push_d;
    end
  end

  // ---- stage: output FIFO
  // The finished sum sits in acc_q for the cycle push_q is high; a new
  // result loading acc_q in that same cycle only lands after the write.
  logic [AB*SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic               full, pop, wr_en;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)   rptr_q <= rptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_q & full & ~pop) ovf_q <= 1'b1;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vmx_result_collector.sv
module tb_vmx_result_collector;

  localparam int SIZE  = 4;
  localparam int PB    = 32;
  localparam int AB    = 40;
  localparam int DEPTH = 8;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic [PB*SIZE-1:0]   product;
  logic [7:0]           acc_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [AB*SIZE-1:0]   out_data;
  logic [3:0]           fifo_count;
  logic                 overflow;

  vmx_result_collector #(
    .SIZE(SIZE), .PRODUCT_BITLEN(PB), .ACC_BITLEN(AB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .product(product),
    .acc_len(acc_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int maxcnt = 0;

  logic          histv [SIZE];
  logic [PB-1:0] histd [SIZE][SIZE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [AB*SIZE-1:0] obs,
                          input logic [AB*SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AB*SIZE-1:0] pack(input longint a0, input longint a1,
                                              input longint a2, input longint a3);
    return {a3[AB-1:0], a2[AB-1:0], a1[AB-1:0], a0[AB-1:0]};
  endfunction

  // One clock: start a pass (or not) and drive each lane with its skew.
  task automatic step(input logic vld, input int l0, input int l1, input int l2, input int l3);
    for (int k = SIZE - 1; k > 0; k--) begin
      histv[k] = histv[k-1];
      for (int j = 0; j < SIZE; j++) histd[k][j] = histd[k-1][j];
    end
    histv[0] = vld;
    histd[0][0] = l0; histd[0][1] = l1; histd[0][2] = l2; histd[0][3] = l3;
    in_valid = histv[0];
    for (int i = 0; i < SIZE; i++)
      product[i*PB +: PB] = histv[i] ? histd[i][i] : 32'h0BAD0BAD;
    @(negedge clk);
    if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 0);
  endtask

  task automatic clear_hist();
    for (int k = 0; k < SIZE; k++) begin
      histv[k] = 1'b0;
      for (int j = 0; j < SIZE; j++) histd[k][j] = '0;
    end
    in_valid = 1'b0;
    product  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_hist();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int maxc);
    for (int n = 0; n < maxc && !out_valid; n++) idle(1);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    acc_len = 8'd1;
    clear_hist();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk_data("rst_out_data", out_data, '0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    idle(2);

    // Single pass, acc_len=1: out_valid exactly at t+5 for one cycle.
    acc_len = 8'd1;
    step(1'b1, 1, 2, 3, 4);
    idle(3);
    chk("lat_early", 64'(out_valid), 64'd0);
    idle(1);
    chk("lat_vld", 64'(out_valid), 64'd1);
    chk_data("lat_data", out_data, pack(1, 2, 3, 4));
    chk("lat_count", 64'(fifo_count), 64'd1);
    idle(1);
    chk("lat_one_cycle", 64'(out_valid), 64'd0);
    idle(2);

    // Three back-to-back passes; acc_len changes after the first beat.
    acc_len = 8'd3;
    maxcnt = 0;
    step(1'b1, 5, 1, 10, -3);
    step(1'b1, -2, 2, 20, -4);
    step(1'b1, 7, 3, 30, -5);
    idle(1);
    acc_len = 8'd1;
    wait_out("acc3", 10);
    chk_data("acc3_data", out_data, pack(10, 6, 60, -12));
    idle(4);
    chk("acc3_single", 64'(out_valid), 64'd0);
    chk("acc3_peak", 64'(maxcnt), 64'd1);

    // Sign extension: -1 + -1 over 40 bits.
    acc_len = 8'd2;
    step(1'b1, -1, 0, 0, 0);
    step(1'b1, -1, 0, 0, 0);
    wait_out("neg", 10);
    chk("neg_lane0", 64'(out_data[AB-1:0]), 64'h00_0000_FFFF_FFFF_FE);
    chk_data("neg_data", out_data, pack(-2, 0, 0, 0));
    idle(3);

    // Nine results into an 8-deep FIFO with no consumer.
    out_ready = 1'b0;
    acc_len = 8'd1;
    for (int k = 1; k <= 9; k++) step(1'b1, k, -k, 100 * k, -1000 * k);
    idle(6);
    chk("full_count", 64'(fifo_count), 64'd8);
    chk("full_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk_data($sformatf("drain_%0d", k), out_data, pack(k, -k, 100 * k, -1000 * k));
      idle(1);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO: push and pop in the same cycle.
    do_reset();
    chk("rst2_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    acc_len = 8'd0;
    for (int k = 1; k <= 8; k++) step(1'b1, k, k + 1, k + 2, k + 3);
    step(1'b1, 9, 10, 11, 12);
    idle(3);
    chk("pp_before", 64'(fifo_count), 64'd8);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("pp_count", 64'(fifo_count), 64'd8);
    chk("pp_overflow", 64'(overflow), 64'd0);
    idle(1);
    chk_data("pp_stable", out_data, pack(2, 3, 4, 5));
    out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk_data($sformatf("pp_drain_%0d", k), out_data, pack(k, k + 1, k + 2, k + 3));
      idle(1);
    end
    chk("pp_empty", 64'(out_valid), 64'd0);

    // Reset in the middle of an accumulation discards the partial sum.
    acc_len = 8'd3;
    step(1'b1, 100, 1, 1, 1);
    step(1'b1, 200, 2, 2, 2);
    idle(4);
    chk("mid_none", 64'(out_valid), 64'd0);
    do_reset();
    step(1'b1, 1, 2, 3, 4);
    step(1'b1, 10, 20, 30, 40);
    step(1'b1, -5, -5, -5, -5);
    wait_out("mid", 10);
    chk_data("mid_data", out_data, pack(6, 17, 28, 39));
    idle(6);
    chk("mid_no_extra", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
